// File: rtl/music_pkg.sv
// Shared types and constants for the melody player.
// Pitch table, sequencer states and the song RAM entry layout.
package music_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PLAY,
    GAP,
    DONE
  } seq_state_t;

  typedef struct packed {
    logic [3:0] pitch;
    logic [3:0] dur;
  } song_entry_t;

  localparam logic [3:0] PITCH_REST = 4'd0;
  localparam logic [3:0] DUR_END    = 4'd0;

  // clkDivider stop values, C..B of the octave holding A = 110 Hz.
  // Index 0 is unused (rest).
  localparam logic [31:0] PITCH_TABLE [13] = '{
    32'h0000_0000,
    32'h0000_2EA9,
    32'h0000_2C0A,
    32'h0000_2991,
    32'h0000_273C,
    32'h0000_2508,
    32'h0000_22F4,
    32'h0000_20FE,
    32'h0000_1F24,
    32'h0000_1D65,
    32'h0000_1BBE,
    32'h0000_1A30,
    32'h0000_18B7
  };

  // Codes 13..15 have no table entry and play as rests.
  function automatic logic is_tone(
    input logic [3:0] p
  );
    return (p != PITCH_REST) && (p <= 4'd12);
  endfunction

endpackage

// File: rtl/beat_timer.sv
// Loadable 32-bit down-counter timing PLAY and GAP intervals.
// Ports: clk, reset_n, load/load_val, count enable, expire pulse.
module beat_timer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic [31:0] load_val,
  input  logic        count,
  output logic        expire
);

  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  // A load of N gives expire in the Nth counting cycle.
  assign expire = count && (cnt_q == 32'd1);

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (count && (cnt_q != 32'd0)) begin
      cnt_d = cnt_q - 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/note_sequencer.sv
// Plays a 16-entry song RAM through one divider/sine voice.
// Ports: start/stop/loop control, RAM write, div_stop/gate/status.
module note_sequencer
  import music_pkg::*;
#(
  parameter int unsigned TICKS_PER_BEAT = 6_250_000,
  parameter int unsigned GAP_TICKS      = 250_000,
  parameter int unsigned SONG_LEN       = 16,
  localparam int unsigned AW = $clog2(SONG_LEN)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          stop,
  input  logic          loop,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  output logic [31:0]   div_stop,
  output logic          gate,
  output logic [AW-1:0] note_addr,
  output logic          busy,
  output logic          done
);

  localparam logic [AW-1:0] LAST = AW'(SONG_LEN - 1);

  if (64'(TICKS_PER_BEAT) * 64'd15 > 64'hFFFF_FFFF) begin : g_tpb_chk
    $error("15*TICKS_PER_BEAT overflows 32 bits");
  end
  if (TICKS_PER_BEAT <= GAP_TICKS) begin : g_gap_chk
    $error("TICKS_PER_BEAT must exceed GAP_TICKS");
  end

  seq_state_t    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          gate_q, gate_d;
  logic [31:0]   div_q, div_d;
  logic [7:0]    ram_q [SONG_LEN];

  song_entry_t   entry;
  logic [31:0]   play_ticks;
  logic          t_load;
  logic          t_count;
  logic          t_expire;
  logic [31:0]   t_val;

  assign entry      = song_entry_t'(ram_q[addr_q]);
  assign play_ticks = 32'(entry.dur) * TICKS_PER_BEAT
                    - GAP_TICKS;

  // Writes only land while idle, so a playing song is stable.
  always_ff @(posedge clk) begin
    if (wr_en && (state_q == IDLE)) begin
      ram_q[wr_addr] <= wr_data;
    end
  end

  beat_timer u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (t_load),
    .load_val (t_val),
    .count    (t_count),
    .expire   (t_expire)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    gate_d  = gate_q;
    div_d   = div_q;
    t_load  = 1'b0;
    t_val   = '0;
    t_count = 1'b0;
    if (stop && (state_q != IDLE)) begin
      state_d = IDLE;
      gate_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start && !stop) begin
            state_d = LOAD;
            addr_d  = '0;
          end
        end
        LOAD: begin
          if (entry.dur == DUR_END) begin
            if (loop) begin
              addr_d = '0;
            end else begin
              state_d = DONE;
            end
          end else begin
            state_d = PLAY;
            t_load  = 1'b1;
            t_val   = play_ticks;
            gate_d  = is_tone(entry.pitch);
            if (is_tone(entry.pitch)) begin
              div_d = PITCH_TABLE[entry.pitch];
            end
          end
        end
        PLAY: begin
          t_count = 1'b1;
          if (t_expire) begin
            state_d = GAP;
            gate_d  = 1'b0;
            t_load  = 1'b1;
            t_val   = GAP_TICKS;
          end
        end
        GAP: begin
          t_count = 1'b1;
          if (t_expire) begin
            if (addr_q == LAST) begin
              if (loop) begin
                state_d = LOAD;
                addr_d  = '0;
              end else begin
                state_d = DONE;
              end
            end else begin
              state_d = LOAD;
              addr_d  = addr_q + 1'b1;
            end
          end
        end
        DONE: begin
          gate_d  = 1'b0;
          state_d = IDLE;
        end
        default: begin
          gate_d  = 1'b0;
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      gate_q  <= 1'b0;
      div_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      gate_q  <= gate_d;
      div_q   <= div_d;
    end
  end

  assign div_stop  = div_q;
  assign gate      = gate_q;
  assign note_addr = addr_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_note_sequencer.sv
// Randomized bench for note_sequencer against a timeline model.
// Model expands each song entry into per-cycle expected outputs.
module tb_note_sequencer;

  localparam int TPB = 10;
  localparam int GAP = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        loop = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic [31:0] div_stop;
  logic        gate;
  logic [3:0]  note_addr;
  logic        busy;
  logic        done;

  note_sequencer #(
    .TICKS_PER_BEAT (TPB),
    .GAP_TICKS      (GAP),
    .SONG_LEN       (16)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .stop      (stop),
    .loop      (loop),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .div_stop  (div_stop),
    .gate      (gate),
    .note_addr (note_addr),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        gate;
    logic [3:0]  addr;
    logic [31:0] div;
  } obs_t;

  // Musical divider values: round(50e6 / (64 * f)), A = 110 Hz.
  localparam logic [31:0] TBL [13] = '{
    32'h0, 32'h2EA9, 32'h2C0A, 32'h2991,
    32'h273C, 32'h2508, 32'h22F4, 32'h20FE,
    32'h1F24, 32'h1D65, 32'h1BBE, 32'h1A30,
    32'h18B7
  };

  int          n_chk = 0;
  int          n_pass = 0;
  logic [7:0]  ram_m [16];
  logic [31:0] div_m = '0;
  obs_t        exp_q [$];
  int          gate_cnt;
  int          done_cnt;
  bit          saw_wrap;

  function automatic obs_t observe();
    obs_t o;
    o.busy = busy;
    o.done = done;
    o.gate = gate;
    o.addr = note_addr;
    o.div  = div_stop;
    return o;
  endfunction

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic push(
    input logic        b,
    input logic        d,
    input logic        g,
    input int          a,
    input logic [31:0] v
  );
    obs_t o;
    o.busy = b;
    o.done = d;
    o.gate = g;
    o.addr = 4'(a);
    o.div  = v;
    exp_q.push_back(o);
  endtask

  // Expected outputs, one per cycle after the start edge.
  // loop is high in cycle k iff k < loop_until.
  task automatic build(input int loop_until);
    int          a;
    int          p;
    int          du;
    bit          lp;
    bit          tone;
    logic [31:0] v;
    a = 0;
    v = div_m;
    exp_q.delete();
    while (exp_q.size() < 4000) begin
      p  = int'(ram_m[a][7:4]);
      du = int'(ram_m[a][3:0]);
      lp = (exp_q.size() < loop_until);
      push(1, 0, 0, a, v);
      if (du == 0) begin
        if (lp) begin
          a = 0;
          continue;
        end
        push(1, 1, 0, a, v);
        push(0, 0, 0, a, v);
        break;
      end
      tone = (p >= 1) && (p <= 12);
      if (tone) v = TBL[p];
      repeat (du * TPB - GAP) push(1, 0, tone, a, v);
      repeat (GAP - 1) push(1, 0, 0, a, v);
      lp = (exp_q.size() < loop_until);
      push(1, 0, 0, a, v);
      if (a == 15) begin
        if (!lp) begin
          push(1, 1, 0, a, v);
          push(0, 0, 0, a, v);
          break;
        end
        a = 0;
      end else begin
        a++;
      end
    end
  endtask

  task automatic wr(input int a, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_addr = 4'(a);
    wr_data = d;
    @(posedge clk);
    #1;
    wr_en   = 1'b0;
    ram_m[a] = d;
  endtask

  task automatic play(
    input string      name,
    input int         loop_until,
    input int         abort_in,
    input bit         abort_rst,
    input bit         noise,
    input bit         wr0,
    input logic [7:0] d0
  );
    obs_t o;
    obs_t last;
    int   abort_at;
    logic [3:0] prev_addr;
    abort_at = abort_in;
    if (wr0) begin
      wr_en    = 1'b1;
      wr_addr  = '0;
      wr_data  = d0;
      ram_m[0] = d0;
    end
    build(loop_until);
    if (abort_at >= exp_q.size() - 1) abort_at = -1;
    if (abort_at >= 0) begin
      last = exp_q[abort_at];
      exp_q = exp_q[0:abort_at];
      if (abort_rst) begin
        last = '0;
      end else begin
        last.busy = 1'b0;
        last.done = 1'b0;
        last.gate = 1'b0;
      end
      exp_q.push_back(last);
      exp_q.push_back(last);
    end
    gate_cnt  = 0;
    done_cnt  = 0;
    saw_wrap  = 1'b0;
    prev_addr = '0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wr_en = 1'b0;
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      o = observe();
      check($sformatf("%s cyc%0d", name, k),
            64'(o), 64'(exp_q[k]));
      if (o.gate) gate_cnt++;
      if (o.done) done_cnt++;
      if (o.busy && prev_addr == 4'd15 && o.addr == 4'd0)
        saw_wrap = 1'b1;
      prev_addr = o.addr;
      loop    = (k < loop_until);
      stop    = (k == abort_at) && !abort_rst;
      reset_n = !((k == abort_at) && abort_rst);
      start   = 1'b0;
      wr_en   = 1'b0;
      if (noise && exp_q[k].busy && k != abort_at
          && k < exp_q.size() - 1) begin
        start   = ($urandom_range(0, 7) == 0);
        wr_en   = ($urandom_range(0, 5) == 0);
        wr_addr = 4'($urandom_range(0, 15));
        wr_data = 8'($urandom);
      end
    end
    start   = 1'b0;
    stop    = 1'b0;
    wr_en   = 1'b0;
    loop    = 1'b0;
    reset_n = 1'b1;
    div_m   = exp_q[exp_q.size() - 1].div;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lu;
    int ab;
    int du;
    repeat (2) @(posedge clk);
    #1;
    check("reset", 64'(observe()), 64'(0));
    reset_n = 1'b1;
    for (int i = 0; i < 16; i++) wr(i, 8'h00);

    wr(0, 8'hA2);
    wr(1, 8'h00);
    play("single", 0, -1, 0, 0, 0, 8'h00);
    check("single gate", 64'(gate_cnt), 64'(18));
    check("single done", 64'(done_cnt), 64'(1));
    check("single div", 64'(div_stop), 64'h1BBE);

    wr(0, 8'h01);
    wr(1, 8'h11);
    wr(2, 8'h00);
    play("rest", 0, -1, 0, 0, 0, 8'h00);
    check("rest gate", 64'(gate_cnt), 64'(8));
    check("rest div", 64'(div_stop), 64'(TBL[1]));

    for (int i = 0; i < 16; i++) wr(i, 8'h51);
    play("loop", 250, -1, 0, 0, 0, 8'h00);
    check("loop done", 64'(done_cnt), 64'(1));
    check("loop wrap", 64'(saw_wrap), 64'(1));

    for (int i = 0; i < 16; i++) wr(i, 8'h32);
    wr(4, 8'h00);
    play("abort", 0, 70, 0, 0, 0, 8'h00);
    check("abort done", 64'(done_cnt), 64'(0));
    play("restart", 0, -1, 0, 0, 0, 8'h00);

    start = 1'b1;
    stop  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    stop  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("start+stop busy", 64'(busy), 64'(0));
      @(posedge clk);
      #1;
    end

    wr(0, 8'hA1);
    wr(1, 8'h00);
    play("busywr", 0, -1, 0, 1, 0, 8'h00);
    play("ramkept", 0, -1, 0, 0, 0, 8'h00);
    play("wrstart", 0, -1, 0, 0, 1, 8'h72);

    wr(0, 8'hA2);
    wr(1, 8'h00);
    play("rstgap", 0, 19, 1, 0, 0, 8'h00);
    play("afterrst", 0, -1, 0, 0, 0, 8'h00);
    check("afterrst gate", 64'(gate_cnt), 64'(18));

    wr(0, 8'h00);
    play("mk0loop", 20, -1, 0, 0, 0, 8'h00);
    check("mk0loop done", 64'(done_cnt), 64'(1));

    repeat (6) begin
      for (int i = 0; i < 16; i++) begin
        du = ($urandom_range(0, 7) == 0)
             ? 0 : int'($urandom_range(1, 3));
        wr(i, {4'($urandom_range(0, 15)), 4'(du)});
      end
      lu = ($urandom_range(0, 1) == 1)
           ? int'($urandom_range(0, 120)) : 0;
      ab = ($urandom_range(0, 3) == 0)
           ? int'($urandom_range(1, 60)) : -1;
      play("rand", lu, ab, 1'($urandom_range(0, 1)),
           1, 0, 8'h00);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
